// File: rtl/pipelined_allocator.sv
// Window-capturing allocator: FIFO-buffered pixel/weight pairs, MACC, bias, saturate, ReLU.
// Build option: define LEAKY_RELU_EN for leaky ReLU (negative r >>> LEAK_SHIFT).
module pipelined_allocator #(
    parameter int DATA_W     = 18,
    parameter int COORD_W    = 8,
    parameter int CNT_W      = 13,
    parameter int HALF_W     = 2,
    parameter int BUF_AW     = 10,
    parameter int ACC_W      = 48,
    parameter int FRAC_BITS  = 0,
    parameter int LEAK_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] center_x,
    input  logic [COORD_W-1:0] center_y,
    input  logic               center_we,
    input  logic [HALF_W-1:0]  filter_halfsize,
    input  logic [CNT_W-1:0]   filter_length,
    input  logic [DATA_W-1:0]  filter_bias,
    input  logic               image_valid,
    input  logic [COORD_W-1:0] image_x,
    input  logic [COORD_W-1:0] image_y,
    input  logic [DATA_W-1:0]  image_data,
    output logic               image_ready,
    input  logic               filter_valid,
    input  logic [DATA_W-1:0]  filter_data,
    output logic               filter_ready,
    output logic               result_valid,
    output logic [DATA_W-1:0]  result_data,
    input  logic               result_ready,
    output logic               busy
);
    localparam int DEPTH = 1 << BUF_AW;
    localparam int PW    = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
    state_t state, state_nx;

    logic [COORD_W-1:0] cx_q, cy_q;
    logic [HALF_W-1:0]  h_q;
    logic [CNT_W-1:0]   len_q, img_cnt, flt_cnt, mac_cnt;
    logic [DATA_W-1:0]  bias_q;

    logic [DATA_W-1:0] img_mem [DEPTH];
    logic [DATA_W-1:0] flt_mem [DEPTH];
    logic [BUF_AW:0]   img_wp, img_rp, flt_wp, flt_rp;
    logic              img_full, img_empty, flt_full, flt_empty;

    logic signed [DATA_W-1:0] a_q, b_q;
    logic signed [PW-1:0]     a_ext, b_ext, prod_q;
    logic signed [ACC_W-1:0]  acc, sum_q, bias_ext;
    logic                     v1, v2, fin;
    logic signed [DATA_W-1:0] sat, act;

    logic signed [COORD_W:0] dx, dy;
    logic [COORD_W:0]        adx, ady, h_ext;
    logic                    hit, run, img_need, img_push, flt_push, pop;

    // Full when pointers differ only in the wrap bit.
    assign img_empty = (img_wp == img_rp);
    assign flt_empty = (flt_wp == flt_rp);
    assign img_full  = (img_wp[BUF_AW] != img_rp[BUF_AW]) &&
                       (img_wp[BUF_AW-1:0] == img_rp[BUF_AW-1:0]);
    assign flt_full  = (flt_wp[BUF_AW] != flt_rp[BUF_AW]) &&
                       (flt_wp[BUF_AW-1:0] == flt_rp[BUF_AW-1:0]);

    // One extra bit keeps the distance exact across coordinate 0 / max.
    always_comb begin
        dx  = $signed({1'b0, image_x}) - $signed({1'b0, cx_q});
        dy  = $signed({1'b0, image_y}) - $signed({1'b0, cy_q});
        adx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
        ady = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    end

    assign h_ext        = {{(COORD_W+1-HALF_W){1'b0}}, h_q};
    assign hit          = (adx <= h_ext) && (ady <= h_ext);
    assign run          = (state == RUN);
    assign img_need     = run && hit && (img_cnt < len_q);
    assign image_ready  = !(img_need && img_full);
    assign img_push     = image_valid && img_need && !img_full;
    assign filter_ready = run && !flt_full && (flt_cnt < len_q);
    assign flt_push     = filter_valid && filter_ready;
    assign pop          = run && !img_empty && !flt_empty && (mac_cnt < len_q);
    assign result_valid = (state == OUT);
    assign busy         = (state != IDLE);

    assign a_ext    = {{DATA_W{a_q[DATA_W-1]}}, a_q};
    assign b_ext    = {{DATA_W{b_q[DATA_W-1]}}, b_q};
    assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (center_we) state_nx = RUN;
            RUN:   if (mac_cnt == len_q) state_nx = DRAIN;
            DRAIN: if (fin) state_nx = OUT;
            OUT:   if (result_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (img_push) img_mem[img_wp[BUF_AW-1:0]] <= image_data;
        if (flt_push) flt_mem[flt_wp[BUF_AW-1:0]] <= filter_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q <= '0; cy_q <= '0; h_q <= '0;
            len_q <= '0; bias_q <= '0;
            img_cnt <= '0; flt_cnt <= '0; mac_cnt <= '0;
            img_wp <= '0; img_rp <= '0; flt_wp <= '0; flt_rp <= '0;
            a_q <= '0; b_q <= '0; prod_q <= '0;
            acc <= '0; sum_q <= '0;
            v1 <= 1'b0; v2 <= 1'b0; fin <= 1'b0;
            result_data <= '0;
        end else begin
            if (state == IDLE && center_we) begin
                cx_q    <= center_x;
                cy_q    <= center_y;
                h_q     <= filter_halfsize;
                len_q   <= filter_length;
                bias_q  <= filter_bias;
                img_cnt <= '0; flt_cnt <= '0; mac_cnt <= '0;
                img_wp  <= '0; img_rp <= '0; flt_wp <= '0; flt_rp <= '0;
                acc     <= '0;
                fin     <= 1'b0;
            end
            if (img_push) begin
                img_wp  <= img_wp + 1'b1;
                img_cnt <= img_cnt + 1'b1;
            end
            if (flt_push) begin
                flt_wp  <= flt_wp + 1'b1;
                flt_cnt <= flt_cnt + 1'b1;
            end
            v1 <= pop;
            if (pop) begin
                a_q     <= img_mem[img_rp[BUF_AW-1:0]];
                b_q     <= flt_mem[flt_rp[BUF_AW-1:0]];
                img_rp  <= img_rp + 1'b1;
                flt_rp  <= flt_rp + 1'b1;
                mac_cnt <= mac_cnt + 1'b1;
            end
            v2 <= v1;
            if (v1) prod_q <= a_ext * b_ext;
            if (v2) acc <= acc + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
            // Two-step finish: bias add, then saturate/activate.
            if (state == DRAIN && !v1 && !v2 && !fin) begin
                fin   <= 1'b1;
                sum_q <= (acc >>> FRAC_BITS) + bias_ext;
            end
            if (state == DRAIN && fin) begin
                fin         <= 1'b0;
                result_data <= act;
            end
        end
    end

    always_comb begin
        sat = sum_q[DATA_W-1:0];
        if (sum_q > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
        else if (sum_q < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
        act = sat;
        if (sat[DATA_W-1]) begin
`ifdef LEAKY_RELU_EN
            act = sat >>> LEAK_SHIFT;
`else
            act = '0;
`endif
        end
    end
endmodule

// File: tb/tb_pipelined_allocator.sv
// Directed bench for pipelined_allocator (small FIFOs, BUF_AW=2).
// Checks capture window, backpressure, MACC latency, saturation, ReLU, reset.
module tb_pipelined_allocator;
    logic        clk = 0;
    logic        rst = 1;
    logic [7:0]  center_x = 0, center_y = 0;
    logic        center_we = 0;
    logic [1:0]  filter_halfsize = 0;
    logic [12:0] filter_length = 0;
    logic [17:0] filter_bias = 0;
    logic        image_valid = 0;
    logic [7:0]  image_x = 0, image_y = 0;
    logic [17:0] image_data = 0;
    logic        image_ready;
    logic        filter_valid = 0;
    logic [17:0] filter_data = 0;
    logic        filter_ready;
    logic        result_valid;
    logic [17:0] result_data;
    logic        result_ready = 0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int ix [1024];
    int iy [1024];
    int idat [1024];
    int fw [64];
    bit first_rdy [1024];

    pipelined_allocator #(.BUF_AW(2)) dut (
        .clk(clk), .rst(rst),
        .center_x(center_x), .center_y(center_y),
        .center_we(center_we), .filter_halfsize(filter_halfsize),
        .filter_length(filter_length), .filter_bias(filter_bias),
        .image_valid(image_valid), .image_x(image_x),
        .image_y(image_y), .image_data(image_data),
        .image_ready(image_ready),
        .filter_valid(filter_valid), .filter_data(filter_data),
        .filter_ready(filter_ready),
        .result_valid(result_valid), .result_data(result_data),
        .result_ready(result_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic arm(input int cx, input int cy, input int h,
                       input int len, input int bias);
        center_x = 8'(cx); center_y = 8'(cy);
        filter_halfsize = 2'(h); filter_length = 13'(len);
        filter_bias = 18'(bias);
        center_we = 1;
        @(posedge clk); #1;
        center_we = 0;
    endtask

    task automatic drive_images(input int n, input int max_wait, output bit to);
        bit r;
        int w;
        to = 0;
        for (int i = 0; i < n; i++) begin
            image_valid = 1;
            image_x = 8'(ix[i]); image_y = 8'(iy[i]);
            image_data = 18'(idat[i]);
            w = 0;
            forever begin
                @(negedge clk);
                r = image_ready;
                if (w == 0) first_rdy[i] = r;
                @(posedge clk); #1;
                if (r) break;
                w++;
                if (w > max_wait) begin to = 1; break; end
            end
            if (to) break;
        end
        image_valid = 0;
    endtask

    task automatic drive_filters(input int n, input int delay,
                                 input int max_wait, output int nacc);
        bit r;
        int w;
        bit to;
        nacc = 0;
        to = 0;
        repeat (delay) begin @(posedge clk); #1; end
        for (int i = 0; i < n; i++) begin
            filter_valid = 1;
            filter_data = 18'(fw[i]);
            w = 0;
            forever begin
                @(negedge clk);
                r = filter_ready;
                @(posedge clk); #1;
                if (r) begin nacc++; break; end
                w++;
                if (w > max_wait) begin to = 1; break; end
            end
            if (to) break;
        end
        filter_valid = 0;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (result_valid) begin ok = 1; break; end
        end
    endtask

    task automatic handshake();
        result_ready = 1;
        @(posedge clk); #1;
        result_ready = 0;
    endtask

    task automatic run_op(input int cx, input int cy, input int h,
                          input int len, input int bias,
                          input int n_img, input int n_flt,
                          input int fdelay, input int fwait,
                          output bit ok, output bit img_to,
                          output int nacc, output logic [17:0] data);
        arm(cx, cy, h, len, bias);
        fork
            drive_images(n_img, 300, img_to);
            drive_filters(n_flt, fdelay, fwait, nacc);
        join
        wait_valid(100, ok);
        data = result_data;
        if (ok) handshake();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks += 5;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", result_valid); end
        if (result_data !== 18'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", result_data); end
        if (filter_ready !== 1'b0) begin errors++; $display("FAIL reset_fr got %b exp 0", filter_ready); end
        if (image_ready !== 1'b1) begin errors++; $display("FAIL reset_ir got %b exp 1", image_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_l_zero();
        logic [17:0] exp;
`ifdef LEAKY_RELU_EN
        exp = 18'(-3);
`else
        exp = 18'd0;
`endif
        arm(0, 0, 0, 0, -24);
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL l0_busy got %b exp 1", busy); end
        if (result_valid !== 1'b0) begin errors++; $display("FAIL l0_rv_a1 got %b exp 0", result_valid); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL l0_rv_a2 got %b exp 0", result_valid); end
        @(negedge clk);
        checks += 2;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL l0_rv_a3 got %b exp 1", result_valid); end
        if (result_data !== exp) begin errors++; $display("FAIL l0_data got %0d exp %0d", $signed(result_data), $signed(exp)); end
        handshake();
    endtask

    task automatic test_raster();
        bit ok, to;
        int nacc;
        logic [17:0] d;
        for (int i = 0; i < 1024; i++) begin
            ix[i] = i % 32; iy[i] = i / 32; idat[i] = 1;
        end
        for (int i = 0; i < 10; i++) fw[i] = 2;
        run_op(10, 10, 1, 9, 5, 1024, 10, 0, 1500, ok, to, nacc, d);
        checks += 4;
        if (to) begin errors++; $display("FAIL raster_img_timeout got 1 exp 0"); end
        if (nacc !== 9) begin errors++; $display("FAIL raster_weights got %0d exp 9", nacc); end
        if (!ok) begin errors++; $display("FAIL raster_valid got 0 exp 1"); end
        if (d !== 18'd23) begin errors++; $display("FAIL raster_data got %0d exp 23", $signed(d)); end
    endtask

    task automatic test_corner();
        bit ok, to;
        int nacc, n;
        int xs [5];
        int ys [4];
        logic [17:0] d;
        xs = '{254, 255, 0, 1, 2};
        ys = '{255, 0, 1, 2};
        n = 0;
        foreach (ys[j]) foreach (xs[k]) begin
            ix[n] = xs[k]; iy[n] = ys[j];
            idat[n] = (xs[k] <= 2 && ys[j] <= 2) ? xs[k] + 4 * ys[j] + 1 : 1000;
            n++;
        end
        for (int i = 0; i < 9; i++) fw[i] = 1;
        run_op(0, 0, 2, 9, 0, n, 9, 0, 300, ok, to, nacc, d);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL corner_valid got 0 exp 1"); end
        if (d !== 18'd54) begin errors++; $display("FAIL corner_data got %0d exp 54", $signed(d)); end
    endtask

    task automatic test_backpressure();
        bit ok, to;
        int nacc;
        logic [17:0] d;
        for (int i = 0; i < 9; i++) begin
            ix[i] = 2 + i % 3; iy[i] = 2 + i / 3; idat[i] = i + 1;
            fw[i] = i + 1;
        end
        run_op(3, 3, 1, 9, -5, 9, 9, 12, 300, ok, to, nacc, d);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (first_rdy[i] !== 1'b1) begin errors++; $display("FAIL bp_ready_hit%0d got 0 exp 1", i + 1); end
        end
        checks += 3;
        if (first_rdy[4] !== 1'b0) begin errors++; $display("FAIL bp_ready_hit5 got 1 exp 0"); end
        if (!ok) begin errors++; $display("FAIL bp_valid got 0 exp 1"); end
        if (d !== 18'd280) begin errors++; $display("FAIL bp_data got %0d exp 280", $signed(d)); end
    endtask

    task automatic test_sign();
        bit ok, to;
        int nacc;
        logic [17:0] d, exp;
        ix[0] = 7; iy[0] = 7; idat[0] = 10;
        ix[1] = 7; iy[1] = 7; idat[1] = 6;
        fw[0] = -5; fw[1] = -5;
`ifdef LEAKY_RELU_EN
        exp = 18'(-10);
`else
        exp = 18'd0;
`endif
        run_op(7, 7, 0, 2, 0, 2, 2, 0, 300, ok, to, nacc, d);
        checks++;
        if (!ok || d !== exp) begin errors++; $display("FAIL relu_neg got %0d exp %0d", $signed(d), $signed(exp)); end
        idat[0] = 131071; fw[0] = 131071;
        run_op(7, 7, 0, 1, 0, 1, 1, 0, 300, ok, to, nacc, d);
        checks++;
        if (!ok || d !== 18'd131071) begin errors++; $display("FAIL sat_pos got %0d exp 131071", $signed(d)); end
        idat[0] = -131072;
`ifdef LEAKY_RELU_EN
        exp = 18'(-16384);
`else
        exp = 18'd0;
`endif
        run_op(7, 7, 0, 1, 0, 1, 1, 0, 300, ok, to, nacc, d);
        checks++;
        if (!ok || d !== exp) begin errors++; $display("FAIL sat_neg got %0d exp %0d", $signed(d), $signed(exp)); end
    endtask

    task automatic test_latency();
        bit ok, to;
        int nacc;
        for (int i = 0; i < 4; i++) begin
            ix[i] = 4 + i % 3; iy[i] = 4 + i / 3; idat[i] = i + 1;
            fw[i] = 1;
        end
        arm(5, 5, 1, 4, 0);
        drive_images(4, 50, to);
        drive_filters(4, 0, 50, nacc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b0) begin errors++; $display("FAIL lat_early%0d got 1 exp 0", i); end
        end
        @(negedge clk);
        checks += 2;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL lat_rise got 0 exp 1"); end
        if (result_data !== 18'd10) begin errors++; $display("FAIL lat_data got %0d exp 10", $signed(result_data)); end
        wait_valid(50, ok);
        if (ok) handshake();
    endtask

    task automatic test_reset_mid();
        bit ok, to;
        int nacc;
        logic [17:0] d;
        for (int i = 0; i < 6; i++) begin
            ix[i] = 5; iy[i] = 5; idat[i] = i + 1; fw[i] = 1;
        end
        arm(5, 5, 1, 9, 0);
        fork
            drive_images(6, 100, to);
            drive_filters(4, 0, 100, nacc);
        join
        repeat (3) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks += 5;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL rmid_rv got %b exp 0", result_valid); end
        if (result_data !== 18'd0) begin errors++; $display("FAIL rmid_rd got %0d exp 0", result_data); end
        if (filter_ready !== 1'b0) begin errors++; $display("FAIL rmid_fr got %b exp 0", filter_ready); end
        if (image_ready !== 1'b1) begin errors++; $display("FAIL rmid_ir got %b exp 1", image_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            ix[i] = 5; iy[i] = 5; idat[i] = 2; fw[i] = 3;
        end
        run_op(5, 5, 1, 9, 3, 9, 9, 0, 300, ok, to, nacc, d);
        checks++;
        if (!ok || d !== 18'd57) begin errors++; $display("FAIL rmid_rearm got %0d exp 57", $signed(d)); end
    endtask

    task automatic test_hold();
        bit ok, to;
        int nacc;
        ix[0] = 5; iy[0] = 5; idat[0] = 3; fw[0] = 4;
        arm(5, 5, 0, 1, 7);
        fork
            drive_images(1, 50, to);
            drive_filters(1, 0, 50, nacc);
        join
        wait_valid(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_valid got 0 exp 1"); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            center_we = (i == 3 || i == 6);
            @(negedge clk);
            checks += 2;
            if (result_valid !== 1'b1) begin errors++; $display("FAIL hold_rv%0d got 0 exp 1", i); end
            if (result_data !== 18'd19) begin errors++; $display("FAIL hold_rd%0d got %0d exp 19", i, $signed(result_data)); end
        end
        @(posedge clk); #1;
        center_we = 1;
        result_ready = 1;
        @(posedge clk); #1;
        center_we = 0;
        result_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 2;
            if (busy !== 1'b0) begin errors++; $display("FAIL post_hs_busy%0d got 1 exp 0", i); end
            if (result_valid !== 1'b0) begin errors++; $display("FAIL post_hs_rv%0d got 1 exp 0", i); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_l_zero();
        test_raster();
        test_corner();
        test_backpressure();
        test_sign();
        test_latency();
        test_reset_mid();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
